// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU-sharing arbiter.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
package alu_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] OP_UADD = 4'd0;
  localparam logic [3:0] OP_SADD = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;

  // Bit positions inside rsp_flags = {cout, lt, eq, gt, v}
  localparam int F_COUT = 4;
  localparam int F_LT   = 3;
  localparam int F_EQ   = 2;
  localparam int F_GT   = 1;
  localparam int F_V    = 0;

  function automatic logic [4:0] pack_flags(input logic cout, input logic lt,
                                            input logic eq, input logic gt,
                                            input logic v);
    logic [4:0] f;
    f         = '0;
    f[F_COUT] = cout;
    f[F_LT]   = lt;
    f[F_EQ]   = eq;
    f[F_GT]   = gt;
    f[F_V]    = v;
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester arbiter: round-robin from ptr, or lowest-index-wins
// when ALU_ARB_FIXED_PRIO_EN is defined (ptr is then ignored).
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_idx,
  output logic             any_req
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N_REQ; k++) begin
      idx = k;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
`else
    // Search starts at ptr and wraps, so the last winner gets lowest priority.
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
`endif
    for (int k = 0; k < N_REQ; k++) begin
      gnt[k] = found && (int'(gnt_idx) == k);
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational 16-bit ALU among N_REQ requesters, one op in flight.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (fixed priority, no rr_ptr).
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DW    = 16,
  parameter int OPW   = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*DW-1:0]  req_x,
  input  logic [N_REQ*DW-1:0]  req_y,
  input  logic [N_REQ-1:0]   req_cin,
  input  logic [N_REQ*OPW-1:0] req_op,
  output logic [DW-1:0]      alu_x,
  output logic [DW-1:0]      alu_y,
  output logic               alu_cin,
  output logic [OPW-1:0]     alu_op,
  input  logic [DW-1:0]      alu_out,
  input  logic               alu_cout,
  input  logic               alu_lt,
  input  logic               alu_eq,
  input  logic               alu_gt,
  input  logic               alu_v,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_out,
  output logic [4:0]         rsp_flags,
  output state_e             dbg_state
);

  // Handshakes: a request transfers when req_valid[i] & req_ready[i] at a rising edge;
  // a response transfers when rsp_valid & rsp_ready at a rising edge. Valid sources hold
  // their payload stable until the transfer.

  state_e state_q, state_d;

  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             any_req;
  logic             grant_en;
  logic             take;
  logic [IDW-1:0]   arb_ptr;

  logic [DW-1:0]    alu_x_q, alu_x_d;
  logic [DW-1:0]    alu_y_q, alu_y_d;
  logic             alu_cin_q, alu_cin_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [DW-1:0]    rsp_out_q, rsp_out_d;
  logic [4:0]       rsp_flags_q, rsp_flags_d;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  assign arb_ptr = rr_ptr_q;
`else
  assign arb_ptr = '0;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (arb_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  // A new grant is possible when idle, or when the pending response leaves this cycle.
  assign grant_en = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign take     = grant_en && any_req;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = EXEC;
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = any_req ? EXEC : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    if (grant_en) req_ready = gnt;
    if (state_q == RESP) rsp_valid = 1'b1;
  end

  // Operand latch, response capture and pointer update
  always_comb begin
    alu_x_d     = alu_x_q;
    alu_y_d     = alu_y_q;
    alu_cin_d   = alu_cin_q;
    alu_op_d    = alu_op_q;
    gnt_id_d    = gnt_id_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_flags_d = rsp_flags_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    if (take) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i]) begin
          alu_x_d   = req_x[i*DW +: DW];
          alu_y_d   = req_y[i*DW +: DW];
          alu_cin_d = req_cin[i];
          alu_op_d  = req_op[i*OPW +: OPW];
        end
      end
      gnt_id_d = gnt_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + IDW'(1);
`endif
    end
    if (state_q == EXEC) begin
      rsp_id_d    = gnt_id_q;
      rsp_out_d   = alu_out;
      rsp_flags_d = pack_flags(alu_cout, alu_lt, alu_eq, alu_gt, alu_v);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      alu_cin_q   <= 1'b0;
      alu_op_q    <= '0;
      gnt_id_q    <= '0;
      rsp_id_q    <= '0;
      rsp_out_q   <= '0;
      rsp_flags_q <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
      alu_cin_q   <= alu_cin_d;
      alu_op_q    <= alu_op_d;
      gnt_id_q    <= gnt_id_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_flags_q <= rsp_flags_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign alu_cin   = alu_cin_q;
  assign alu_op    = alu_op_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_flags = rsp_flags_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter with a small behavioural ALU and a response scoreboard.
// Build with ALU_ARB_FIXED_PRIO_EN defined to exercise the fixed-priority variant.
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  localparam int N_REQ = 2;
  localparam int DW    = 16;
  localparam int OPW   = 4;
  localparam int IDW   = 2;
  localparam int RW    = IDW + DW + 5;

  logic               clk;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*DW-1:0]  req_x;
  logic [N_REQ*DW-1:0]  req_y;
  logic [N_REQ-1:0]   req_cin;
  logic [N_REQ*OPW-1:0] req_op;
  logic [DW-1:0]      alu_x, alu_y, alu_out;
  logic               alu_cin, alu_cout, alu_lt, alu_eq, alu_gt, alu_v;
  logic [OPW-1:0]     alu_op;
  logic               rsp_valid, rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_out;
  logic [4:0]         rsp_flags;
  state_e             dbg_state;

  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  alu_share_arbiter #(.N_REQ(N_REQ), .DW(DW), .OPW(OPW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_cin(req_cin), .req_op(req_op),
    .alu_x(alu_x), .alu_y(alu_y), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_lt(alu_lt), .alu_eq(alu_eq),
    .alu_gt(alu_gt), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_flags(rsp_flags), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural ALU: op1 with cin=1 subtracts; compares are unsigned.
  logic [DW:0]   alu_sum;
  logic [DW-1:0] alu_yy;
  always_comb begin
    alu_yy   = (alu_op == OP_SADD && alu_cin) ? ~alu_y : alu_y;
    alu_sum  = {1'b0, alu_x} + {1'b0, alu_yy} + {{DW{1'b0}}, alu_cin};
    alu_out  = '0;
    alu_cout = 1'b0;
    alu_v    = 1'b0;
    case (alu_op)
      OP_UADD, OP_SADD: begin
        alu_out  = alu_sum[DW-1:0];
        alu_cout = alu_sum[DW];
        alu_v    = (alu_x[DW-1] == alu_yy[DW-1]) && (alu_sum[DW-1] != alu_x[DW-1]);
      end
      OP_AND:  alu_out = alu_x & alu_y;
      OP_OR:   alu_out = alu_x | alu_y;
      default: alu_out = '0;
    endcase
    alu_lt = alu_x < alu_y;
    alu_eq = alu_x == alu_y;
    alu_gt = alu_x > alu_y;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every response transfer is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d out=%0h flags=%b with nothing expected",
                 rsp_id, rsp_out, rsp_flags);
      end else begin
        check("rsp_id_out_flags", 32'({rsp_id, rsp_out, rsp_flags}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic issue(input int id, input logic [15:0] x, input logic [15:0] y,
                       input logic [3:0] op, input logic cin,
                       input logic [15:0] e_out, input logic [4:0] e_fl, input bit push);
    req_x[id*DW +: DW]   = x;
    req_y[id*DW +: DW]   = y;
    req_op[id*OPW +: OPW] = op;
    req_cin[id]          = cin;
    req_valid[id]        = 1'b1;
    if (push) exp_q.push_back({IDW'(id), e_out, e_fl});
  endtask

  task automatic wait_accept(input int id);
    int b;
    b = 0;
    @(negedge clk);
    while (!req_ready[id] && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!req_ready[id]) check("accept_timeout", 32'(req_ready[id]), 32'd1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 50) begin
      @(posedge clk);
      b++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int seq[4];
    int cnt;
    int b;
    rst       = 1'b1;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    req_cin   = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_out", 32'(rsp_out), 32'd0);
    check("reset_rsp_flags", 32'(rsp_flags), 32'd0);
    check("reset_alu_regs", 32'({alu_x, alu_cin, alu_op}), 32'd0);
    check("reset_alu_y", 32'(alu_y), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1 rst = 1'b0;

    // Single op with latency check
    issue(0, 16'd1, 16'd2, OP_UADD, 1'b0, 16'd3, 5'b01000, 1'b1);
    @(negedge clk);
    check("t1_req_ready", 32'(req_ready), 32'b01);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    check("t1_rsp_valid_n1", 32'(rsp_valid), 32'd0);
    check("t1_alu_x_latched", 32'(alu_x), 32'd1);
    @(negedge clk);
    check("t1_rsp_valid_n2", 32'(rsp_valid), 32'd1);
    drain();

    // Overflow / carry
    issue(0, 16'h8000, 16'h8000, OP_SADD, 1'b0, 16'h0000, 5'b10101, 1'b1);
    wait_accept(0);
    drain();
    issue(1, 16'hFFFF, 16'h0001, OP_UADD, 1'b0, 16'h0000, 5'b10010, 1'b1);
    wait_accept(1);
    drain();

    // Logic ops
    issue(0, 16'h5AEE, 16'hF0FC, OP_AND, 1'b0, 16'h50EC, 5'b01000, 1'b1);
    wait_accept(0);
    drain();
    issue(1, 16'h5AEE, 16'hF0FC, OP_OR, 1'b0, 16'hFAFE, 5'b01000, 1'b1);
    wait_accept(1);
    drain();

    // Backpressure: response held stable, no grants while rsp_ready is low
    rsp_ready = 1'b0;
    issue(1, 16'd300, 16'd200, OP_SADD, 1'b1, 16'd100, 5'b10010, 1'b1);
    wait_accept(1);
    issue(0, 16'd5, 16'd5, OP_AND, 1'b0, 16'd5, 5'b00100, 1'b1);
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_out", 32'(rsp_out), 32'd100);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_accept(0);
    drain();

    // Reset while an op is executing
    issue(0, 16'd9, 16'd9, OP_UADD, 1'b0, 16'd18, 5'b00100, 1'b0);
    wait_accept(0);
    check("t6_in_exec", 32'(dbg_state), 32'(EXEC));
    rst = 1'b1;
    #1;
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_state_idle", 32'(dbg_state), 32'(IDLE));
    check("t6_alu_x_clr", 32'(alu_x), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t6_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;

    // Contention: both requesters held valid
`ifdef ALU_ARB_FIXED_PRIO_EN
    seq = '{0, 0, 0, 0};
`else
    seq = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      if (seq[i] == 0) exp_q.push_back({IDW'(0), 16'd20, 5'b00100});
      else             exp_q.push_back({IDW'(1), 16'd7, 5'b00010});
    end
    issue(0, 16'd10, 16'd10, OP_UADD, 1'b0, 16'd0, 5'd0, 1'b0);
    issue(1, 16'd7, 16'd3, OP_OR, 1'b0, 16'd0, 5'd0, 1'b0);
    cnt = 0;
    b   = 0;
    while (cnt < 4 && b < 60) begin
      @(negedge clk);
      if (|req_ready) cnt++;
      b++;
      @(posedge clk);
    end
    #1 req_valid = '0;
    check("contention_grants", 32'(cnt), 32'd4);
    drain();

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
